// File: rtl/present_dec_core.sv
// Iterative PRESENT-80 decryptor (31 rounds).
// The user key is first expanded forward to K32 in 31 cycles; the final
// whitening is then removed and 31 inverse rounds are run. Each inverse round
// walks the key schedule backwards one step per cycle.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    decrypt request; key_i/block_i are sampled with it in IDLE
//   key_i    80-bit user key
//   block_i  64-bit ciphertext
//   block_o  64-bit plaintext, held until the next completion
//   busy     high while the key expansion or the decryption is running
//   done     one-cycle pulse when block_o is valid
module present_dec_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key_i,
  input  logic [63:0] block_i,
  output logic [63:0] block_o,
  output logic        busy,
  output logic        done
);

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned BLK_W  = 64;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ROUNDS = 31;

  typedef enum logic [1:0] {IDLE, KEY_FWD, DECRYPT, DONE} fsm_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] key_reg;
  logic [BLK_W-1:0] state_reg;

  logic [KEY_W-1:0] key_fwd_nxt;
  logic [KEY_W-1:0] key_inv_nxt;
  logic [BLK_W-1:0] round_nxt;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  // Forward schedule step: rotate left 61, S-box top nibble, inject counter.
  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                               input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  // Exact inverse of key_fwd for the same counter value.
  function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                               input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ c;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  // Output bit j takes input bit 16*(j mod 4) + j/4.
  function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      r[j] = s[16 * (j % 4) + (j / 4)];
    end
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] dec_round(input logic [BLK_W-1:0] s,
                                                 input logic [KEY_W-1:0] k);
    logic [BLK_W-1:0] t;
    logic [BLK_W-1:0] r;
    t = inv_player(s);
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = inv_sbox(t[4*i +: 4]);
    end
    return r ^ k[79:16];
  endfunction

  // Datapath for the current step.
  assign key_fwd_nxt = key_fwd(key_reg, cnt);
  assign key_inv_nxt = key_inv(key_reg, cnt);
  assign round_nxt   = dec_round(state_reg, key_inv_nxt);

  // Control FSM with registered busy/done/block_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      key_reg   <= '0;
      state_reg <= '0;
      block_o   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_reg   <= key_i;
            state_reg <= block_i;
            cnt       <= CNT_W'(1);
            busy      <= 1'b1;
            fsm       <= KEY_FWD;
          end
        end
        KEY_FWD: begin
          key_reg <= key_fwd_nxt;
          if (cnt == CNT_W'(ROUNDS)) begin
            // key_fwd_nxt is K32 here: strip the final whitening.
            state_reg <= state_reg ^ key_fwd_nxt[79:16];
            cnt       <= CNT_W'(ROUNDS);
            fsm       <= DECRYPT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DECRYPT: begin
          key_reg   <= key_inv_nxt;
          state_reg <= round_nxt;
          if (cnt == CNT_W'(1)) begin
            block_o <= round_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            fsm     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_dec_core.sv
// Directed bench for present_dec_core using the published PRESENT-80 vectors.
module tb_present_dec_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [79:0] key_i;
  logic [63:0] block_i;
  logic [63:0] block_o;
  logic        busy;
  logic        done;

  int tests;
  int failed;

  localparam logic [79:0] K0  = 80'h0;
  localparam logic [79:0] K1  = 80'hFFFFFFFFFFFFFFFFFFFF;
  localparam logic [63:0] C00 = 64'h5579C1387B228445;
  localparam logic [63:0] C10 = 64'hE72C46C0F5945049;
  localparam logic [63:0] C01 = 64'hA112FFC72F68417B;
  localparam logic [63:0] C11 = 64'h3333DCD3213210D2;
  localparam logic [63:0] P0  = 64'h0;
  localparam logic [63:0] P1  = 64'hFFFFFFFFFFFFFFFF;

  present_dec_core dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key_i   (key_i),
    .block_i (block_i),
    .block_o (block_o),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: latency, result, single done pulse, result hold.
  task automatic run_op(input logic [79:0] k, input logic [63:0] b,
                        input logic [63:0] exp, input string tag);
    int n;
    key_i   = k;
    block_i = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    key_i   = ~k;
    block_i = ~b;
    check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(62));
    check({tag, "_block_o"}, block_o, exp);
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    tick();
    check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
    tick();
    tick();
    check({tag, "_block_o_hold"}, block_o, exp);
  endtask

  initial begin
    int dcnt;
    int last_done;
    tests   = 0;
    failed  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    key_i   = '0;
    block_i = '0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset_block_o", block_o, P0);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Known-answer vectors; the last two run back-to-back without reset
    run_op(K0, C00, P0, "kat_k0_p0");
    run_op(K1, C10, P0, "kat_k1_p0");
    run_op(K0, C01, P1, "kat_k0_p1");
    run_op(K1, C11, P1, "kat_k1_p1");

    // start pulsed mid-operation with other data is ignored
    key_i   = K0;
    block_i = C01;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    dcnt    = 0;
    for (int n = 1; n <= 70; n++) begin
      if (n == 10) begin
        key_i   = K0;
        block_i = C00;
        start   = 1'b1;
      end
      if (n == 11) start = 1'b0;
      tick();
      if (done === 1'b1) begin
        dcnt++;
        check("restart_ignored_block_o", block_o, P1);
        check("restart_ignored_latency", 64'(n), 64'(62));
      end
    end
    check("restart_ignored_done_count", 64'(dcnt), 64'(1));

    // Reset in the middle of an operation aborts it
    key_i   = K1;
    block_i = C10;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int n = 1; n <= 40; n++) tick();
    rst = 1'b1;
    #1;
    check("midrst_block_o", block_o, P0);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    tick();
    tick();
    rst  = 1'b0;
    dcnt = 0;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    check("midrst_no_done", 64'(dcnt), 64'(0));
    run_op(K0, C00, P0, "after_rst");

    // start held high: one new operation every 64 cycles
    key_i     = K0;
    block_i   = C01;
    start     = 1'b1;
    tick();
    dcnt      = 0;
    last_done = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      check($sformatf("held_busy_c%0d", n), 64'(busy),
            64'(((n % 64) != 62) && ((n % 64) != 63)));
      check($sformatf("held_done_c%0d", n), 64'(done), 64'((n % 64) == 62));
      if (done === 1'b1) begin
        dcnt++;
        check($sformatf("held_block_o_c%0d", n), block_o, P1);
        if (last_done >= 0) check("held_period", 64'(n - last_done), 64'(64));
        last_done = n;
      end
    end
    start = 1'b0;
    check("held_done_count", 64'(dcnt), 64'(3));

    // Drain the operation that was in flight when start dropped
    begin
      int w;
      w = 0;
      while (done !== 1'b1 && w < 100) begin
        tick();
        w++;
      end
      check("held_drain_done_seen", 64'(done), 64'(1));
      check("held_drain_block_o", block_o, P1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/present_dec_core.md
PRESENT_DEC_CORE -- requirements
Module: present_dec_core

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to decrypt, sampled on the rising edge of clk.
REQ-005 key_i  input  80  PRESENT-80 user key, sampled together with start.
REQ-006 block_i  input  64  ciphertext, sampled together with start.
REQ-007 block_o  output  64  recovered plaintext.
REQ-008 busy  output  1  high from the edge after an accepted start until the edge on which done rises.
REQ-009 done  output  1  one-cycle pulse when block_o is valid.

Function
REQ-010 The block SHALL be an iterative PRESENT-80 decryptor (31 rounds) that inverts PRESENT-80 encryption bit-exactly.
REQ-011 Bit conventions: bit 0 SHALL be the LSB; the round key SHALL be key_reg[79:16]; the S-box SHALL be applied per nibble [4i+3:4i].
REQ-012 Forward key update with counter c:
- rotate key_reg left by 61;
- apply the PRESENT S-box to [79:76];
- XOR c[4:0] into [19:15].
REQ-013 Inverse key update with counter c:
- XOR c[4:0] into [19:15];
- apply the inverse S-box to [79:76];
- rotate left by 19.
REQ-014 A decryption round with key K SHALL compute: state = invSbox(invPlayer(state)) ^ K[79:16].
- invPlayer moves input bit 16*(j mod 4) + j/4 to output bit j.
REQ-015 FSM states and transitions:
- IDLE -> KEY_FWD on start;
- KEY_FWD -> DECRYPT after 31 cycles;
- DECRYPT -> DONE after 31 cycles;
- DONE -> IDLE unconditionally.
REQ-016 In IDLE with start=1: key_reg<=key_i, state_reg<=block_i, cnt<=1, next state KEY_FWD.
REQ-017 Each KEY_FWD edge SHALL apply the forward update with cnt, then increment cnt.
REQ-018 On the KEY_FWD edge with cnt=31, the key SHALL become K32, and state_reg SHALL become state_reg ^ K32[79:16] (final whitening removed).
- cnt SHALL be set to 31 and the FSM SHALL enter DECRYPT.
REQ-019 Each DECRYPT edge SHALL apply the inverse key update with cnt, giving K_cnt, and then one decryption round using that K_cnt, then decrement cnt.
REQ-020 On the DECRYPT edge with cnt=1, block_o SHALL be loaded with the new state and the FSM SHALL enter DONE.
REQ-021 done SHALL be 1 only in DONE (exactly one cycle).
REQ-022 busy SHALL be 1 in KEY_FWD and DECRYPT.
REQ-023 Latency: start sampled at edge E0 SHALL give done=1 and valid block_o after edge E62, a fixed 62-cycle latency.
REQ-024 start SHALL be ignored in KEY_FWD, DECRYPT and DONE; the key and block are not resampled.
REQ-025 start held high continuously SHALL start a new operation on every IDLE edge.
- Back-to-back period: 64 cycles.
REQ-026 block_o SHALL hold its last value until it is overwritten by the next completion.
REQ-027 cnt SHALL be 5 bits and SHALL never wrap: its range is 1..31.

Reset
REQ-028 When rst is asserted: FSM=IDLE, cnt=0, key_reg=0, state_reg=0, block_o=0, busy=0, done=0, immediately and independent of clk.
REQ-029 rst asserted mid-operation SHALL abort the operation with no done pulse.
- The first start sampled after rst deasserts SHALL begin a fresh operation.

Verification
REQ-030 key=0, block_i=64'h5579C1387B228445 -> block_o=64'h0000000000000000, done after 62 cycles.
REQ-031 key=80'hFFFFFFFFFFFFFFFFFFFF, block_i=64'hE72C46C0F5945049 -> block_o=64'h0.
REQ-032 key=0, block_i=64'hA112FFC72F68417B -> block_o=64'hFFFFFFFFFFFFFFFF.
- Then with no reset, key=all ones, block_i=64'h3333DCD3213210D2 -> block_o=64'hFFFFFFFFFFFFFFFF.
REQ-033 Pulse start again at cycle 10 of an operation with different data -> the result matches the first operation's vector; exactly one done pulse.
REQ-034 Assert rst at cycle 40 of an operation -> all outputs 0, no done; then start with the REQ-030 vector -> correct result 62 cycles later.
REQ-035 start held high for 200 cycles with a fixed vector -> done pulses 64 cycles apart, correct block_o each time, busy low only in DONE and IDLE.
